// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: ALU operations, immediate formats, opcodes,
// result-mux encodings and the decode queue entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_src_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Result mux: ALU, load data, PC+4 (links), PC+imm (AUIPC target adder in EX).
    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_MEM   = 2'b01;
    localparam logic [1:0] RES_PC4   = 2'b10;
    localparam logic [1:0] RES_PCIMM = 2'b11;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } decode_entry_t;

endpackage

// File: rtl/controller.sv
// Main decoder: opcode/funct fields to pipeline controls, immediate format
// and an illegal flag for opcodes outside RV32I base integer ops.
module controller
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       reg_write,
    output logic       mem_write,
    output logic       jump,
    output logic       branch,
    output logic       alu_src,
    output logic [1:0] result_src,
    output alu_op_e    alu_control,
    output imm_src_e   imm_src,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output is defaulted first so no branch of the case can infer a latch.
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        case (op)
            OP_R:      reg_write = 1'b1;
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm_src = IMM_B;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_PC4;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_U;
            end
            OP_AUIPC: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_PCIMM;
                imm_src    = IMM_U;
            end
            default:   illegal = 1'b1;
        endcase
    end

    // funct7[5] selects SUB for R-type only, but SRA for both R and I shifts.
    always_comb begin
        alu_control = ALU_ADD;
        if (op == OP_R || op == OP_I) begin
            case (funct3)
                3'b000:  alu_control = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
        end else if (op == OP_BRANCH) begin
            alu_control = ALU_SUB;
        end else if (op == OP_LUI) begin
            alu_control = ALU_LUI;
        end
    end

endmodule

// File: rtl/imm_extend.sv
// Immediate extraction for I/S/B/J/U formats, sign-extended to XLEN.
module imm_extend #(
    parameter int XLEN = 32
) (
    input  logic [31:7]         instr,
    input  riscv_pkg::imm_src_e imm_src,
    output logic [XLEN-1:0]     imm_ext
);

    logic signed [31:0] imm32;

    always_comb begin
        case (imm_src)
            riscv_pkg::IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            riscv_pkg::IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            riscv_pkg::IMM_B: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            riscv_pkg::IMM_J: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            riscv_pkg::IMM_U: imm32 = {instr[31:12], 12'b0};
            default:          imm32 = '0;
        endcase
    end

    // Signed source, so widening to XLEN sign-extends.
    assign imm_ext = XLEN'(imm32);

endmodule

// File: rtl/instr_queue.sv
// Circular FIFO between fetch and decode: DEPTH entries (power of two),
// valid/ready on both sides, flush drops everything. No same-cycle pass-through.
module instr_queue #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_stall,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Ready looks only at the registered count, so no path from the stall input.
    assign push_ready = !rst && (count != CW'(DEPTH));
    assign pop_valid  = !rst && (count != '0);
    assign push       = push_valid && push_ready && !flush;
    assign pop        = pop_valid && !pop_stall && !flush;
    assign head_data  = mem[rd_ptr];

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile.sv
// 32 x XLEN register file: two combinational read ports, one write port on
// posedge clk. x0 is hardwired to zero.
module regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      a1,
    input  logic [4:0]      a2,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] rf [32];

    always_ff @(posedge clk) begin
        if (we && a3 != 5'd0) rf[a3] <= wd;
    end

    assign rd1 = (a1 == 5'd0) ? '0 : rf[a1];
    assign rd2 = (a2 == 5'd0) ? '0 : rf[a2];

endmodule

// File: rtl/decode_queued.sv
// Decode stage fed by a DEPTH-entry instruction queue with valid/ready toward fetch.
// Optional macro DECODE_WB_BYPASS_EN: writeback data is forwarded into RD1D/RD2D same cycle.
module decode_queued #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ValidF,
    output logic                         ReadyF,
    input  logic [31:0]                  InstrF,
    input  logic [XLEN-1:0]              PCF,
    input  logic [XLEN-1:0]              PCPlus4F,
    input  logic                         StallD,
    input  logic                         FlushD,
    input  logic                         RegWriteW,
    input  logic [4:0]                   RdW,
    input  logic [XLEN-1:0]              ResultW,
    output logic                         ValidD,
    output logic                         IllegalD,
    output logic                         RegWriteD,
    output logic                         MemWriteD,
    output logic                         JumpD,
    output logic                         BranchD,
    output logic                         ALUSrcD,
    output logic [1:0]                   ResultSrcD,
    output riscv_pkg::alu_op_e           ALUControlD,
    output logic [XLEN-1:0]              RD1D,
    output logic [XLEN-1:0]              RD2D,
    output logic [XLEN-1:0]              PCD,
    output logic [XLEN-1:0]              PCPlus4D,
    output logic [XLEN-1:0]              ExtImmD,
    output logic [4:0]                   Rs1D,
    output logic [4:0]                   Rs2D,
    output logic [4:0]                   RdD,
    output logic [$clog2(DEPTH+1)-1:0]   CountD
);

    localparam int EW = 32 + 2 * XLEN;

    logic [EW-1:0]       head;
    logic [31:0]         instr_d;
    logic                reg_write_c;
    logic                mem_write_c;
    logic                jump_c;
    logic                branch_c;
    logic                alu_src_c;
    logic                illegal_c;
    logic                bubble;
    logic [1:0]          result_src_c;
    riscv_pkg::alu_op_e  alu_control_c;
    riscv_pkg::imm_src_e imm_src_c;
    logic [XLEN-1:0]     rd1_rf;
    logic [XLEN-1:0]     rd2_rf;

    instr_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (FlushD),
        .push_valid (ValidF),
        .push_ready (ReadyF),
        .push_data  ({InstrF, PCF, PCPlus4F}),
        .pop_valid  (ValidD),
        .pop_stall  (StallD),
        .head_data  (head),
        .count      (CountD)
    );

    assign {instr_d, PCD, PCPlus4D} = head;
    assign Rs1D = instr_d[19:15];
    assign Rs2D = instr_d[24:20];
    assign RdD  = instr_d[11:7];

    controller u_ctrl (
        .op          (instr_d[6:0]),
        .funct3      (instr_d[14:12]),
        .funct7b5    (instr_d[30]),
        .reg_write   (reg_write_c),
        .mem_write   (mem_write_c),
        .jump        (jump_c),
        .branch      (branch_c),
        .alu_src     (alu_src_c),
        .result_src  (result_src_c),
        .alu_control (alu_control_c),
        .imm_src     (imm_src_c),
        .illegal     (illegal_c)
    );

    imm_extend #(.XLEN(XLEN)) u_imm (
        .instr   (instr_d[31:7]),
        .imm_src (imm_src_c),
        .imm_ext (ExtImmD)
    );

    regfile #(.XLEN(XLEN)) u_rf (
        .clk (clk),
        .we  (RegWriteW),
        .a1  (Rs1D),
        .a2  (Rs2D),
        .a3  (RdW),
        .wd  (ResultW),
        .rd1 (rd1_rf),
        .rd2 (rd2_rf)
    );

    // A bubble must never commit architectural side effects downstream.
    assign bubble    = !ValidD || illegal_c;
    assign IllegalD  = ValidD && illegal_c;
    assign RegWriteD = reg_write_c && !bubble;
    assign MemWriteD = mem_write_c && !bubble;
    assign JumpD     = jump_c && !bubble;
    assign BranchD   = branch_c && !bubble;

    assign ALUSrcD     = alu_src_c && !rst;
    assign ResultSrcD  = rst ? riscv_pkg::RES_ALU : result_src_c;
    assign ALUControlD = rst ? riscv_pkg::ALU_ADD : alu_control_c;

`ifdef DECODE_WB_BYPASS_EN
    assign RD1D = (RegWriteW && RdW != 5'd0 && RdW == Rs1D) ? ResultW : rd1_rf;
    assign RD2D = (RegWriteW && RdW != 5'd0 && RdW == Rs2D) ? ResultW : rd2_rf;
`else
    // Without write-through the hazard unit covers WB->D with an extra stall.
    assign RD1D = rd1_rf;
    assign RD2D = rd2_rf;
`endif

endmodule

// File: tb/tb_decode_queued.sv
// Self-checking bench for decode_queued: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_decode_queued;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            ValidF;
    logic            ReadyF;
    logic [31:0]     InstrF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic            StallD;
    logic            FlushD;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            ValidD;
    logic            IllegalD;
    logic            RegWriteD;
    logic            MemWriteD;
    logic            JumpD;
    logic            BranchD;
    logic            ALUSrcD;
    logic [1:0]      ResultSrcD;
    alu_op_e         ALUControlD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [XLEN-1:0] ExtImmD;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;
    logic [CW-1:0]   CountD;

    int tests = 0;
    int fails = 0;
    logic [31:0] rf_model [32];

    always #5 clk = ~clk;

    decode_queued #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ValidF(ValidF), .ReadyF(ReadyF), .InstrF(InstrF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .StallD(StallD), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ValidD(ValidD),
        .IllegalD(IllegalD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ExtImmD(ExtImmD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RdD(RdD), .CountD(CountD)
    );

    typedef struct {
        bit          legal;
        bit          rw;
        bit          mw;
        bit          j;
        bit          br;
        bit          has_imm;
        logic [31:0] imm;
    } exp_t;

    // ISA-level decode: which instruction classes write, store, jump, branch, and their immediates.
    function automatic exp_t expect_decode(input logic [31:0] i);
        exp_t x = '{default: 0};
        logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
        logic [31:0] imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        logic [31:0] imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        logic [31:0] imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        logic [31:0] imm_u = i & 32'hFFFF_F000;
        x.legal   = 1;
        x.has_imm = 1;
        case (i[6:0])
            OP_R:             begin x.rw = 1; x.has_imm = 0; end
            OP_I, OP_LOAD:    begin x.rw = 1; x.imm = imm_i; end
            OP_STORE:         begin x.mw = 1; x.imm = imm_s; end
            OP_BRANCH:        begin x.br = 1; x.imm = imm_b; end
            OP_JAL:           begin x.rw = 1; x.j = 1; x.imm = imm_j; end
            OP_JALR:          begin x.rw = 1; x.j = 1; x.imm = imm_i; end
            OP_LUI, OP_AUIPC: begin x.rw = 1; x.imm = imm_u; end
            default:          begin x.legal = 0; x.has_imm = 0; end
        endcase
        return x;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (RegWriteW && RdW != 5'd0 && RdW == a) return ResultW;
`endif
        return rf_model[a];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom();
        logic [6:0]  op;
        case ($urandom_range(0, 10))
            0:       op = OP_R;
            1:       op = OP_I;
            2:       op = OP_LOAD;
            3:       op = OP_STORE;
            4:       op = OP_BRANCH;
            5:       op = OP_JAL;
            6:       op = OP_JALR;
            7:       op = OP_LUI;
            8:       op = OP_AUIPC;
            9:       op = 7'h7F;
            default: op = 7'h0F;
        endcase
        return {r[31:7], op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ValidF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        RegWriteW = 1'b0;
        RdW       = 5'd0;
        ResultW   = '0;
        InstrF    = 32'h0000_0013;
        PCF       = '0;
        PCPlus4F  = 32'd4;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        ValidF   = 1'b1;
        InstrF   = instr;
        PCF      = pc;
        PCPlus4F = pc + 32'd4;
        step();
        ValidF   = 1'b0;
    endtask

    task automatic flush();
        FlushD = 1'b1;
        step();
        FlushD = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        #1;
        tests++; if ({ValidD, ReadyF, CountD} !== {2'b00, CW'(0)}) begin fails++;
            $display("FAIL reset_status: got valid=%0b ready=%0b count=%0d expected 0/0/0", ValidD, ReadyF, CountD); end
        tests++; if ({RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD, ResultSrcD} !== 8'd0) begin fails++;
            $display("FAIL reset_controls: got %b expected 00000000", {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD, ResultSrcD}); end
        rst = 1'b0;
        #1;
        tests++; if (ReadyF !== 1'b1) begin fails++;
            $display("FAIL reset_release_ready: got %0b expected 1", ReadyF); end
        step();
    endtask

    task automatic init_regs();
        rf_model[0] = 32'd0;
        for (int r = 1; r < 32; r++) begin
            RegWriteW   = 1'b1;
            RdW         = 5'(r);
            ResultW     = $urandom();
            rf_model[r] = ResultW;
            step();
        end
        RegWriteW = 1'b0;
        RdW       = 5'd0;
    endtask

    task automatic test_addi();
        push(32'h0050_0093, 32'h0);
        #1;
        tests++; if ({ValidD, RegWriteD, ALUSrcD, IllegalD} !== 4'b1110) begin fails++;
            $display("FAIL addi_ctrl: got valid/rw/alusrc/ill=%b expected 1110", {ValidD, RegWriteD, ALUSrcD, IllegalD}); end
        tests++; if (ExtImmD !== 32'h5) begin fails++;
            $display("FAIL addi_imm: got %h expected 00000005", ExtImmD); end
        tests++; if ({RdD, Rs1D, CountD} !== {5'd1, 5'd0, CW'(1)}) begin fails++;
            $display("FAIL addi_fields: got rd=%0d rs1=%0d count=%0d expected 1/0/1", RdD, Rs1D, CountD); end
        tests++; if ({ALUControlD, RD1D, PCD, PCPlus4D} !== {ALU_ADD, 32'd0, 32'h0, 32'h4}) begin fails++;
            $display("FAIL addi_data: got alu=%0d rd1=%h pc=%h pc4=%h", ALUControlD, RD1D, PCD, PCPlus4D); end
        step();
        #1;
        tests++; if ({CountD, ValidD, RegWriteD} !== {CW'(0), 2'b00}) begin fails++;
            $display("FAIL addi_drain: got count=%0d valid=%0b rw=%0b expected 0/0/0", CountD, ValidD, RegWriteD); end
    endtask

    task automatic test_full_stall();
        logic [31:0] snap_pc;
        logic [31:0] snap_imm;
        StallD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ValidF   = 1'b1;
            InstrF   = {12'(i), 5'd0, 3'd0, 5'(i + 1), OP_I};
            PCF      = 32'(4 * i);
            PCPlus4F = 32'(4 * i + 4);
            #1;
            tests++; if (ReadyF !== (i < DEPTH)) begin fails++;
                $display("FAIL full_ready push %0d: got %0b expected %0b", i, ReadyF, (i < DEPTH)); end
            step();
        end
        ValidF = 1'b0;
        #1;
        tests++; if ({CountD, ReadyF, PCD} !== {CW'(DEPTH), 1'b0, 32'h0}) begin fails++;
            $display("FAIL full_state: got count=%0d ready=%0b pc=%h expected 4/0/0", CountD, ReadyF, PCD); end
        snap_pc  = PCD;
        snap_imm = ExtImmD;
        step();
        #1;
        tests++; if ({CountD, PCD, ExtImmD} !== {CW'(DEPTH), snap_pc, snap_imm}) begin fails++;
            $display("FAIL full_hold: got count=%0d pc=%h imm=%h", CountD, PCD, ExtImmD); end
        StallD = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            tests++; if ({ValidD, PCD, ExtImmD} !== {1'b1, 32'(4 * i), 32'(i)}) begin fails++;
                $display("FAIL full_drain %0d: got valid=%0b pc=%h imm=%h expected pc=%h", i, ValidD, PCD, ExtImmD, 32'(4 * i)); end
            step();
        end
        #1;
        tests++; if (CountD !== CW'(0)) begin fails++;
            $display("FAIL full_empty: got count=%0d expected 0", CountD); end
    endtask

    task automatic test_flush();
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h0010_0093, 32'(16 * i));
        ValidF = 1'b1;
        FlushD = 1'b1;
        #1;
        tests++; if (CountD !== CW'(3)) begin fails++;
            $display("FAIL flush_pre_count: got %0d expected 3", CountD); end
        step();
        FlushD = 1'b0;
        ValidF = 1'b0;
        StallD = 1'b0;
        #1;
        tests++; if ({CountD, ValidD, RegWriteD, ReadyF} !== {CW'(0), 3'b001}) begin fails++;
            $display("FAIL flush_post: got count=%0d valid=%0b rw=%0b ready=%0b expected 0/0/0/1", CountD, ValidD, RegWriteD, ReadyF); end
        StallD = 1'b1;
        push(32'h0010_0093, 32'h40);
        push(32'h0010_0093, 32'h44);
        ValidF = 1'b1;
        rst    = 1'b1;
        #1;
        tests++; if ({ReadyF, ValidD, RegWriteD} !== 3'b000) begin fails++;
            $display("FAIL midreset_during: got ready=%0b valid=%0b rw=%0b expected 0/0/0", ReadyF, ValidD, RegWriteD); end
        step();
        rst    = 1'b0;
        ValidF = 1'b0;
        StallD = 1'b0;
        #1;
        tests++; if ({CountD, ValidD} !== {CW'(0), 1'b0}) begin fails++;
            $display("FAIL midreset_after: got count=%0d valid=%0b expected 0/0", CountD, ValidD); end
    endtask

    task automatic test_stream();
        StallD = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ValidF   = 1'b1;
            InstrF   = {12'(i), 5'd0, 3'd0, 5'd5, OP_I};
            PCF      = 32'h100 + 32'(4 * i);
            PCPlus4F = 32'h104 + 32'(4 * i);
            if (i > 0) begin
                #1;
                tests++; if ({ValidD, ReadyF, CountD, PCD} !== {2'b11, CW'(1), 32'h100 + 32'(4 * (i - 1))}) begin fails++;
                    $display("FAIL stream %0d: got valid=%0b ready=%0b count=%0d pc=%h expected pc=%h",
                             i, ValidD, ReadyF, CountD, PCD, 32'h100 + 32'(4 * (i - 1))); end
            end
            step();
        end
        ValidF = 1'b0;
        #1;
        tests++; if ({CountD, PCD} !== {CW'(1), 32'h124}) begin fails++;
            $display("FAIL stream_last: got count=%0d pc=%h expected 1/00000124", CountD, PCD); end
        step();
        #1;
        tests++; if (CountD !== CW'(0)) begin fails++;
            $display("FAIL stream_empty: got %0d expected 0", CountD); end
    endtask

    task automatic test_illegal();
        StallD = 1'b1;
        push(32'h0000_02FF, 32'h200);
        #1;
        tests++; if ({ValidD, IllegalD} !== 2'b11) begin fails++;
            $display("FAIL illegal_flag: got valid=%0b illegal=%0b expected 1/1", ValidD, IllegalD); end
        tests++; if ({RegWriteD, MemWriteD, JumpD, BranchD} !== 4'b0000) begin fails++;
            $display("FAIL illegal_bubble: got %b expected 0000", {RegWriteD, MemWriteD, JumpD, BranchD}); end
        flush();
        StallD = 1'b0;
    endtask

    task automatic test_bypass();
        logic [31:0] old;
        StallD = 1'b1;
        push(32'h0001_8213, 32'h300);
        old       = rf_model[3];
        RegWriteW = 1'b1;
        RdW       = 5'd3;
        ResultW   = 32'hDEAD_BEEF;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        tests++; if (RD1D !== 32'hDEAD_BEEF) begin fails++;
            $display("FAIL bypass_same_cycle: got %h expected deadbeef", RD1D); end
`else
        tests++; if (RD1D !== old) begin fails++;
            $display("FAIL nobypass_same_cycle: got %h expected %h", RD1D, old); end
`endif
        step();
        rf_model[3] = 32'hDEAD_BEEF;
        RegWriteW   = 1'b0;
        #1;
        tests++; if (RD1D !== 32'hDEAD_BEEF) begin fails++;
            $display("FAIL bypass_next_cycle: got %h expected deadbeef", RD1D); end
        flush();
        push(32'h0030_0233, 32'h304);
        RegWriteW = 1'b1;
        RdW       = 5'd0;
        ResultW   = 32'h1234_5678;
        #1;
        tests++; if ({RD1D, RD2D} !== {32'd0, 32'hDEAD_BEEF}) begin fails++;
            $display("FAIL x0_write_same: got rd1=%h rd2=%h expected 0/deadbeef", RD1D, RD2D); end
        step();
        RegWriteW = 1'b0;
        #1;
        tests++; if ({RD1D, RD2D} !== {32'd0, 32'hDEAD_BEEF}) begin fails++;
            $display("FAIL x0_write_after: got rd1=%h rd2=%h expected 0/deadbeef", RD1D, RD2D); end
        flush();
        StallD = 1'b0;
    endtask

    task automatic test_random();
        decode_entry_t q[$];
        for (int c = 0; c < 400; c++) begin
            decode_entry_t e;
            exp_t          x;
            logic [31:0]   hi;
            bit            vexp;
            bit            rexp;
            logic [4:0]    ce;
            e.instr    = rand_instr();
            e.pc       = $urandom() & 32'hFFFF_FFFC;
            e.pc_plus4 = e.pc + 32'd4;
            ValidF     = ($urandom_range(0, 3) != 0);
            InstrF     = e.instr;
            PCF        = e.pc;
            PCPlus4F   = e.pc_plus4;
            StallD     = ($urandom_range(0, 3) == 0);
            FlushD     = ($urandom_range(0, 29) == 0);
            RegWriteW  = 1'($urandom_range(0, 1));
            RdW        = 5'($urandom_range(0, 31));
            ResultW    = $urandom();
            #1;
            vexp = (q.size() != 0);
            rexp = (q.size() != DEPTH);
            tests++; if ({ValidD, ReadyF, CountD} !== {vexp, rexp, CW'(q.size())}) begin fails++;
                $display("FAIL rand_status c%0d: got valid=%0b ready=%0b count=%0d expected %0b/%0b/%0d",
                         c, ValidD, ReadyF, CountD, vexp, rexp, q.size()); end
            if (vexp) begin
                hi = q[0].instr;
                x  = expect_decode(hi);
                ce = {!x.legal, x.rw, x.mw, x.j, x.br};
                tests++; if ({PCD, PCPlus4D, Rs1D, Rs2D, RdD} !== {q[0].pc, q[0].pc_plus4, hi[19:15], hi[24:20], hi[11:7]}) begin fails++;
                    $display("FAIL rand_head c%0d: got pc=%h rs1=%0d rs2=%0d rd=%0d expected pc=%h instr=%h",
                             c, PCD, Rs1D, Rs2D, RdD, q[0].pc, hi); end
                tests++; if ({IllegalD, RegWriteD, MemWriteD, JumpD, BranchD} !== ce) begin fails++;
                    $display("FAIL rand_ctrl c%0d instr=%h: got %b expected %b", c, hi,
                             {IllegalD, RegWriteD, MemWriteD, JumpD, BranchD}, ce); end
                if (x.has_imm) begin
                    tests++; if (ExtImmD !== x.imm) begin fails++;
                        $display("FAIL rand_imm c%0d instr=%h: got %h expected %h", c, hi, ExtImmD, x.imm); end
                end
                tests++; if ({RD1D, RD2D} !== {exp_read(hi[19:15]), exp_read(hi[24:20])}) begin fails++;
                    $display("FAIL rand_regs c%0d: got rd1=%h rd2=%h expected %h/%h", c, RD1D, RD2D,
                             exp_read(hi[19:15]), exp_read(hi[24:20])); end
            end else begin
                tests++; if ({IllegalD, RegWriteD, MemWriteD, JumpD, BranchD} !== 5'b00000) begin fails++;
                    $display("FAIL rand_empty_ctrl c%0d: got %b expected 00000", c,
                             {IllegalD, RegWriteD, MemWriteD, JumpD, BranchD}); end
            end
            if (FlushD) begin
                q.delete();
            end else begin
                if (vexp && !StallD) void'(q.pop_front());
                if (ValidF && rexp)  q.push_back(e);
            end
            if (RegWriteW && RdW != 5'd0) rf_model[RdW] = ResultW;
            step();
        end
        idle();
        flush();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_regs();
        test_addi();
        test_full_stall();
        test_flush();
        test_stream();
        test_illegal();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
